// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII serializer: character width, FSM encoding
// and a few character constants.
package ascii_pkg;

  localparam int unsigned DEFAULT_CHAR_W = 7;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  localparam logic [6:0] AsciiUpperA = 7'h41;
  localparam logic [6:0] AsciiUpperZ = 7'h5A;
  localparam logic [6:0] AsciiNul    = 7'h00;
  localparam logic [6:0] AsciiDel    = 7'h7F;

endpackage

// File: rtl/char_fifo.sv
// Small character FIFO with an occupancy counter; synchronous active-high reset.
module char_fifo #(
  parameter int unsigned CHAR_W = 7,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [CHAR_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [CHAR_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the counter MSB alone marks full.
  assign full_o  = cnt_q[AW];
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ascii_serializer.sv
// Buffers ASCII characters and shifts them out MSB first, back-to-back, with
// per-bit qualifiers for the downstream serial-to-parallel converter.
module ascii_serializer
  import ascii_pkg::*;
#(
  parameter int unsigned CHAR_W = DEFAULT_CHAR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data,
  output logic              bit_valid,
  output logic              first_bit,
  output logic              busy,
  output logic [7:0]        char_count
);

  localparam int unsigned IW = $clog2(CHAR_W);
  localparam logic [IW-1:0] LastIdx = IW'(CHAR_W - 1);

  logic [0:0]        state_q, state_d;
  logic [CHAR_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [CHAR_W-1:0] fifo_rdata;

  char_fifo #(
    .CHAR_W(CHAR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (in_valid),
    .wdata_i(in_char),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          idx_d    = LastIdx;
          state_d  = StShift;
        end
      end
      StShift: begin
        shreg_d = shreg_q << 1;
        idx_d   = idx_q - IW'(1);
        if (idx_q == '0) begin
          cnt_d = cnt_q + 8'd1;
          // Reload immediately so consecutive characters have no gap bit.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            idx_d    = LastIdx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign bit_valid  = (state_q == StShift);
  assign data       = bit_valid && shreg_q[CHAR_W-1];
  assign first_bit  = bit_valid && (idx_q == LastIdx);
  assign busy       = bit_valid || !fifo_empty;
  assign char_count = cnt_q;

endmodule

// File: tb/tb_ascii_serializer.sv
// Self-checking bench for ascii_serializer: queue-based reference model,
// table-driven single-character vectors, directed corner cases and random traffic.
module tb_ascii_serializer;
  import ascii_pkg::*;

  localparam int CW  = 7;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] in_char = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, data, bit_valid, first_bit, busy;
  logic [7:0]    char_count;

  ascii_serializer #(
    .CHAR_W(CW),
    .DEPTH (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_char   (in_char),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .bit_valid (bit_valid),
    .first_bit (first_bit),
    .busy      (busy),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: characters waiting, bits still to show for the current one.
  logic [CW-1:0] m_q[$];
  bit            m_bits[$];
  int            m_count = 0;
  logic [CW-1:0] sent[$];
  bit            last_acc = 0;

  logic [CW-1:0] asm_w = '0;
  int            asm_n = 0;
  int            bv_count = 0;
  int            bv_first = -1;
  int            bv_last = -1;

  typedef struct {
    logic [CW-1:0] ch;
    logic [CW-1:0] bits;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [CW-1:0] ch;
    bit acc = 0;
    if (rst) begin
      m_q.delete();
      m_bits.delete();
      sent.delete();
      m_count = 0;
      asm_n = 0;
    end else begin
      acc = in_valid && (m_q.size() < DEP);
      if (m_bits.size() <= 1) begin
        if (m_bits.size() == 1) begin
          m_bits.delete();
          m_count = (m_count + 1) % 256;
        end
        if (m_q.size() > 0) begin
          ch = m_q.pop_front();
          for (int i = CW - 1; i >= 0; i--) m_bits.push_back(ch[i]);
        end
      end else begin
        void'(m_bits.pop_front());
      end
      if (acc) begin
        m_q.push_back(in_char);
        sent.push_back(in_char);
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEP));
    chk("bit_valid", 32'(bit_valid), 32'(m_bits.size() > 0));
    chk("data", 32'(data), (m_bits.size() > 0) ? 32'(m_bits[0]) : 32'd0);
    chk("first_bit", 32'(first_bit), 32'(m_bits.size() == CW));
    chk("busy", 32'(busy), 32'((m_bits.size() > 0) || (m_q.size() > 0)));
    chk("char_count", 32'(char_count), 32'(m_count));
    if (bit_valid === 1'b1) begin
      bv_count++;
      if (bv_first < 0) bv_first = cyc;
      bv_last = cyc;
      if (first_bit === 1'b1) asm_n = 0;
      asm_w = {asm_w[CW-2:0], data};
      asm_n++;
      if (asm_n == CW) begin
        asm_n = 0;
        if (sent.size() > 0) chk("char_order", 32'(asm_w), 32'(sent.pop_front()));
        else chk("char_unexpected", 32'(asm_w), 32'hFFFF);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [CW-1:0] ch);
    int n = 0;
    in_valid = 1'b1;
    in_char = ch;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [CW-1:0] cap;
    int n;

    tbl[0] = '{AsciiUpperA, 7'b1000001};
    tbl[1] = '{7'h48,       7'b1001000};
    tbl[2] = '{7'h69,       7'b1101001};
    tbl[3] = '{AsciiUpperZ, 7'b1011010};
    tbl[4] = '{AsciiDel,    7'b1111111};
    tbl[5] = '{AsciiNul,    7'b0000000};

    tick();
    do_reset();
    chk("rst_count", 32'(char_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Single characters: one idle cycle after acceptance, then 7 bits MSB first.
    foreach (tbl[k]) begin
      in_valid = 1'b1;
      in_char = tbl[k].ch;
      tick();
      in_valid = 1'b0;
      chk("tbl_latency", 32'(bit_valid), 32'd0);
      cap = '0;
      for (int i = 0; i < CW; i++) begin
        tick();
        chk("tbl_bv", 32'(bit_valid), 32'd1);
        chk("tbl_first", 32'(first_bit), 32'(i == 0));
        cap = {cap[CW-2:0], data};
      end
      chk("tbl_bits", 32'(cap), 32'(tbl[k].bits));
      tick();
      chk("tbl_idle_data", 32'(data), 32'd0);
      chk("tbl_idle_busy", 32'(busy), 32'd0);
    end
    chk("tbl_count", 32'(char_count), 32'd6);

    // Two characters back-to-back: 14 contiguous bits.
    do_reset();
    bv_count = 0; bv_first = -1; bv_last = -1;
    send(7'h48);
    send(7'h69);
    drain();
    chk("hi_count", 32'(char_count), 32'd2);
    chk("hi_bits", 32'(bv_count), 32'd14);
    chk("hi_contig", 32'(bv_last - bv_first + 1), 32'd14);

    // Six characters pushed while the shifter runs; in_ready throttles.
    do_reset();
    for (int i = 0; i < 6; i++) send(7'(7'h30 + i));
    drain();
    chk("six_count", 32'(char_count), 32'd6);

    // Reset while bit 3 of 'Z' is on the wire, two characters queued.
    do_reset();
    send(AsciiUpperZ);
    send(AsciiUpperA);
    send(7'h42);
    n = 0;
    while (m_bits.size() != 4 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_bit3", 32'(m_bits.size()), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_bv", 32'(bit_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(char_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    bv_count = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_no_bits", 32'(bv_count), 32'd0);

    // 256 alternating DEL/NUL characters: count wraps, no idle cycles.
    do_reset();
    bv_count = 0; bv_first = -1; bv_last = -1;
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? AsciiDel : AsciiNul);
    drain();
    chk("wrap_count", 32'(char_count), 32'd0);
    chk("wrap_bits", 32'(bv_count), 32'd1792);
    chk("wrap_contig", 32'(bv_last - bv_first + 1), 32'd1792);

    // Push while full on the same edge as an internal pop.
    do_reset();
    for (int i = 0; i < 5; i++) send(7'(7'h61 + i));
    in_valid = 1'b1;
    in_char = 7'h33;
    n = 0;
    while (m_bits.size() != 1 && n < 20) begin
      tick();
      n++;
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_pop_ready", 32'(in_ready), 32'd1);
    tick();
    chk("full_accept_refill", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("full_count", 32'(char_count), 32'd6);

    // Random traffic with upstream hold semantics.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_char = 7'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    drain();
    chk("rand_leftover", 32'(sent.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_serializer.md
Name: ascii_serializer

Overview:
- Upstream stage of the ASCII serial-to-parallel converter: accepts 7-bit ASCII characters over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each character out one bit per clock, MSB (bit 6) first, which is the order the downstream converter assembles into its 7-bit word.
- Characters stream back-to-back with no gap bits, so the downstream 7-bit counter stays aligned from reset.
- bit_valid and first_bit qualify each bit so downstream logic can gate and check framing.

Parameters:
- CHAR_W, 7, bits per character; bit CHAR_W-1 is sent first.
- DEPTH, 4, FIFO depth in characters; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_char  input  CHAR_W  character to enqueue.
- in_valid  input  1  in_char is valid this cycle.
- in_ready  output  1  FIFO can accept a character; equals !full.
- data  output  1  serial bit out (feeds converter data input).
- bit_valid  output  1  data carries a character bit this cycle.
- first_bit  output  1  data carries bit CHAR_W-1 of a character.
- busy  output  1  shifter active or FIFO non-empty.
- char_count  output  8  number of characters fully shifted out; wraps 255 -> 0.

Behaviour:
- Reset (rst=1 at a rising edge): FIFO emptied, pointers=0, state=IDLE, data=0, bit_valid=0, first_bit=0, busy=0, char_count=0, in_ready=1 on the following cycle. Reset mid-character drops the partial character and all queued characters; no further bits are emitted.
- Enqueue: in_valid && in_ready at edge E writes in_char. in_ready is combinational !full only; a pop in the same cycle does not make room when full. A character offered while in_ready=0 is not taken and the upstream holds it.
- FSM states:
  - IDLE: data=0, bit_valid=0. At an edge with FIFO non-empty: pop the head into a CHAR_W shift register, set bit index=CHAR_W-1, go to SHIFT.
  - SHIFT: data = shreg[CHAR_W-1], bit_valid=1, first_bit=1 only while index=CHAR_W-1. Each edge shifts left and decrements the index.
  - At the edge ending index=0: char_count increments. If the FIFO is non-empty, pop the next character and stay in SHIFT with index reset, giving zero gap cycles. Otherwise go to IDLE.
- Latency: a character written at edge E into an empty FIFO with IDLE state is loaded at edge E+1. Its bits appear in the 7 cycles following E+1, MSB first.
- Outputs are registered; data, bit_valid and first_bit change only on clock edges.
- Simultaneous push and pop when not full: both occur and the count is unchanged. Push when full: ignored (in_ready=0). Pop when empty: never occurs.
- Pointers are log2(DEPTH) bits with natural wrap; full and empty are derived from an occupancy counter of log2(DEPTH)+1 bits.
- busy = (state==SHIFT) || !empty.

Decomposition:
- Shared package ascii_pkg holds:
  - CHAR_W default = 7;
  - the state encoding (IDLE=1'b0, SHIFT=1'b1);
  - ASCII constants used by the benches ('A'=7'h41, 'Z'=7'h5A, NUL=7'h00, DEL=7'h7F).
- One natural sub-module: char_fifo (parameterised CHAR_W and DEPTH; push/pop/full/empty, synchronous reset). The top contains the FSM, the shift register and char_count.

Test Plan:
- Reset, then in_valid with 7'h41 for one cycle -> starting one cycle after acceptance, data = 1,0,0,0,0,0,1 with bit_valid=1 for 7 cycles and first_bit only on the first. char_count becomes 1, busy drops, data returns to 0.
- Push 'H'(7'h48), 'i'(7'h69) on consecutive cycles -> 14 contiguous bit_valid cycles, bits 1001000 then 1101001, first_bit at cycles 1 and 8, char_count=2. Checked by feeding data into the downstream converter and seeing ascii=7'h48 then 7'h69, each with complete asserted.
- Hold in_valid high with 6 characters while the shifter runs -> in_ready falls after DEPTH characters are queued, no character is lost or duplicated, and the output order matches the input order.
- Assert rst for one cycle at bit 3 of 7'h5A with 2 characters queued -> the next cycle has bit_valid=0, busy=0, char_count=0, in_ready=1, and no further bits are emitted.
- Stream 256 characters of 7'h7F and 7'h00 alternating -> char_count wraps to 0. The bit stream alternates seven 1s and seven 0s with no idle cycle in between.
- Push when full in the same cycle as an internal pop -> the push is rejected (in_ready=0); the next cycle in_ready=1 and the push is accepted.
